icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 19 +
 rtl/icache_array.sv | 46 ++++
 rtl/icache.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared constants and types for the instruction cache.
// FSM state encoding, address field widths, tag width helper.
package icache_pkg;

  localparam int ADDR_W         = 32;
  localparam int WORD_W         = 32;
  localparam int OFF_BITS       = 2;
  localparam int DEF_INDEX_BITS = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_t;

  function automatic int tag_bits(input int ib);
    return ADDR_W - ib - OFF_BITS;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid bits (reset), tag and data (not reset).
// Ports: rd_idx -> rd_valid/rd_tag/rd_data (comb); wr_* synchronous write.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = tag_bits(DEF_INDEX_BITS)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [WORD_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [WORD_W-1:0]     wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [WORD_W-1:0]   data_q [LINES];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Blocking direct-mapped instruction cache, one word per line.
// Ports: fetch side if_*, refill side mem_*, rdy_in stall, clear flush.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              if_en_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  output logic              if_valid_o,
  output logic [WORD_W-1:0] if_inst_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_en_i,
  input  logic [WORD_W-1:0] mem_data_i
);

  localparam int TAG_BITS = tag_bits(INDEX_BITS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:2] pc_q, pc_d;
  logic              vld_q, vld_d;
  logic [WORD_W-1:0] inst_q, inst_d;
  logic              men_q, men_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              pend_q, pend_d;
  logic [WORD_W-1:0] pdata_q, pdata_d;

  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [WORD_W-1:0]   rd_data;
  logic                wr_en;
  logic                hit;
  logic                done;
  logic [WORD_W-1:0]   fill;
  logic                unused_pc;

  assign unused_pc = ^if_pc_i[1:0];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_idx   (if_pc_i[INDEX_BITS+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (pc_q[INDEX_BITS+1:2]),
    .wr_tag   (pc_q[ADDR_W-1:INDEX_BITS+2]),
    .wr_data  (fill)
  );

  assign hit = rd_valid &&
               (rd_tag == if_pc_i[ADDR_W-1:INDEX_BITS+2]);

  // A refill-done pulse seen while stalled is kept until rdy_in returns.
  assign done = mem_en_i | pend_q;
  assign fill = pend_q ? pdata_q : mem_data_i;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      vld_q   <= 1'b0;
      inst_q  <= '0;
      men_q   <= 1'b0;
      maddr_q <= '0;
      pend_q  <= 1'b0;
      pdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      inst_q  <= inst_d;
      men_q   <= men_d;
      maddr_q <= maddr_d;
      pend_q  <= pend_d;
      pdata_q <= pdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    inst_d  = inst_q;
    men_d   = men_q;
    maddr_d = maddr_q;
    pend_d  = pend_q;
    pdata_d = pdata_q;
    wr_en   = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      vld_d   = 1'b0;
      men_d   = 1'b0;
      pend_d  = 1'b0;
    end else if (!rdy_in) begin
      if (state_q == S_MISS && mem_en_i && !pend_q) begin
        pend_d  = 1'b1;
        pdata_d = mem_data_i;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          vld_d  = 1'b0;
          men_d  = 1'b0;
          pend_d = 1'b0;
          // No acceptance while answering, so a held request fires once.
          if (if_en_i && !vld_q) begin
            if (hit) begin
              vld_d  = 1'b1;
              inst_d = rd_data;
            end else begin
              pc_d    = if_pc_i[ADDR_W-1:2];
              men_d   = 1'b1;
              maddr_d = {if_pc_i[ADDR_W-1:2], 2'b00};
              state_d = S_MISS;
            end
          end
        end
        S_MISS: begin
          if (done) begin
            wr_en   = 1'b1;
            vld_d   = 1'b1;
            inst_d  = fill;
            men_d   = 1'b0;
            pend_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign if_valid_o = vld_q;
  assign if_inst_o  = inst_q;
  assign mem_en_o   = men_q;
  assign mem_addr_o = maddr_q;

endmodule
